// File: rtl/tage_pkg.sv
// Shared TAGE predictor definitions: default counter width and the
// hit-rate reporting window, plus the report-slot action encoding.
package tage_pkg;

  // Width of every branch/instruction index counter in the predictor.
  localparam int DEFAULT_INSTRUCTION_INDEX_SIZE = 22;

  // Number of resolved branches per hit-rate report.
  localparam int unsigned DEFAULT_WINDOW = 100000;

  // What the one-entry report buffer does on a given edge.
  typedef enum logic [1:0] {
    SLOT_IDLE, // nothing happens, held report (if any) stays
    SLOT_LOAD, // capture a new report (slot empty or being popped)
    SLOT_DROP, // new report arrives while one is held and not popped
    SLOT_POP   // consumer takes the held report, nothing new arrives
  } slot_action_e;

endpackage : tage_pkg

// File: rtl/stats_report_slot.sv
// One-entry report buffer with valid/ready handshake. A report arriving while
// another is still held (and not popped this cycle) is dropped and flags a
// sticky overrun.
module stats_report_slot
  import tage_pkg::*;
#(
  parameter int WIDTH = DEFAULT_INSTRUCTION_INDEX_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_total,
  input  logic [WIDTH-1:0] load_correct,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] total,
  output logic [WIDTH-1:0] window_correct,
  output logic             overrun
);

  slot_action_e action;

  // Decide this cycle's slot action; a pop frees the slot for a same-cycle load.
  always_comb begin
    // NOTE: default first so every path assigns action and no latch is inferred.
    action = SLOT_IDLE;
    if (load && (!valid || ready)) begin
      action = SLOT_LOAD;
    end else if (load) begin
      action = SLOT_DROP;
    end else if (valid && ready) begin
      action = SLOT_POP;
    end
  end

  // Report register, valid flag and sticky overrun; clear wipes everything.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (rst) begin
      valid          <= 1'b0;
      total          <= '0;
      window_correct <= '0;
      overrun        <= 1'b0;
    end else if (clear) begin
      valid          <= 1'b0;
      total          <= '0;
      window_correct <= '0;
      overrun        <= 1'b0;
    end else begin
      case (action)
        SLOT_LOAD: begin
          valid          <= 1'b1;
          total          <= load_total;
          window_correct <= load_correct;
        end
        SLOT_DROP: overrun <= 1'b1;
        SLOT_POP:  valid   <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule : stats_report_slot

// File: rtl/branch_stats_monitor.sv
// Branch prediction statistics: saturating running totals of resolved and
// correctly predicted branches, plus a per-window hit-rate report handed to a
// consumer through a one-entry valid/ready slot.
module branch_stats_monitor
  import tage_pkg::*;
#(
  parameter int          INSTRUCTION_INDEX_SIZE = DEFAULT_INSTRUCTION_INDEX_SIZE,
  parameter int unsigned WINDOW                 = DEFAULT_WINDOW
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              Clear,
  input  logic                              ResolveValid,
  input  logic                              Prediction,
  input  logic                              Outcome,
  output logic                              PredictionCorrect,
  output logic [INSTRUCTION_INDEX_SIZE-1:0] CorrectlyPredicted,
  output logic [INSTRUCTION_INDEX_SIZE-1:0] TotalBranches,
  output logic                              ReportValid,
  input  logic                              ReportReady,
  output logic [INSTRUCTION_INDEX_SIZE-1:0] ReportTotal,
  output logic [INSTRUCTION_INDEX_SIZE-1:0] ReportWindowCorrect,
  output logic                              ReportOverrun
);

  localparam int W = INSTRUCTION_INDEX_SIZE;
  localparam logic [W-1:0] COUNT_MAX   = '1;
  localparam logic [W-1:0] ONE         = W'(1);
  localparam logic [W-1:0] WINDOW_LAST = W'(WINDOW - 1);

  logic         accept;        // branch taken into the statistics this cycle
  logic         correct;       // presented branch was predicted correctly
  logic         total_sat;     // total counter pinned at all-ones
  logic         counted;       // accepted branch that still advances the window
  logic         window_close;  // this acceptance completes a window
  logic [W-1:0] total_inc;
  logic [W-1:0] win_correct_sum;

  logic [W-1:0] total_q;
  logic [W-1:0] correct_q;
  logic [W-1:0] win_cnt_q;
  logic [W-1:0] win_correct_q;
  logic         pred_correct_q;

  // Acceptance, saturation and window-close decode for the current branch.
  always_comb begin
    accept          = ResolveValid && !Clear;
    correct         = (Prediction == Outcome);
    total_sat       = (total_q == COUNT_MAX);
    // Once the total saturates, windows stop advancing so no report can close.
    counted         = accept && !total_sat;
    window_close    = counted && (win_cnt_q == WINDOW_LAST);
    total_inc       = total_q + ONE;
    win_correct_sum = win_correct_q + {{(W-1){1'b0}}, correct};
  end

  // Running saturating counters, window counters and last-branch correctness.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      total_q        <= '0;
      correct_q      <= '0;
      win_cnt_q      <= '0;
      win_correct_q  <= '0;
      pred_correct_q <= 1'b0;
    end else if (Clear) begin
      total_q        <= '0;
      correct_q      <= '0;
      win_cnt_q      <= '0;
      win_correct_q  <= '0;
      pred_correct_q <= 1'b0;
    end else if (accept) begin
      pred_correct_q <= correct;
      if (!total_sat) begin
        total_q <= total_inc;
      end
      // Correct count is bounded by the total, but saturate it independently anyway.
      if (correct && (correct_q != COUNT_MAX)) begin
        correct_q <= correct_q + ONE;
      end
      if (counted) begin
        if (window_close) begin
          win_cnt_q     <= '0;
          win_correct_q <= '0;
        end else begin
          win_cnt_q     <= win_cnt_q + ONE;
          win_correct_q <= win_correct_sum;
        end
      end
    end
  end

  // Closing window hands the new total and its correct count to the report slot.
  stats_report_slot #(
    .WIDTH(W)
  ) u_report_slot (
    .clk           (Clk),
    .rst           (Rst),
    .clear         (Clear),
    .load          (window_close),
    .load_total    (total_inc),
    .load_correct  (win_correct_sum),
    .ready         (ReportReady),
    .valid         (ReportValid),
    .total         (ReportTotal),
    .window_correct(ReportWindowCorrect),
    .overrun       (ReportOverrun)
  );

  assign PredictionCorrect  = pred_correct_q;
  assign CorrectlyPredicted = correct_q;
  assign TotalBranches      = total_q;

endmodule : branch_stats_monitor

// File: tb/tb_branch_stats_monitor.sv
// Testbench for branch_stats_monitor (WINDOW=4, 8-bit counters). Expected
// reports are queued when the closing branch is issued; a monitor pops and
// compares them whenever the DUT hands a report over.
module tb_branch_stats_monitor;

  localparam int N   = 8;
  localparam int WIN = 4;

  typedef struct {
    int total;
    int wcorrect;
  } report_t;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Clear;
  logic         ResolveValid;
  logic         Prediction;
  logic         Outcome;
  logic         PredictionCorrect;
  logic [N-1:0] CorrectlyPredicted;
  logic [N-1:0] TotalBranches;
  logic         ReportValid;
  logic         ReportReady;
  logic [N-1:0] ReportTotal;
  logic [N-1:0] ReportWindowCorrect;
  logic         ReportOverrun;

  report_t exp_q[$];
  int      check_count = 0;
  int      pass_count  = 0;

  branch_stats_monitor #(
    .INSTRUCTION_INDEX_SIZE(N),
    .WINDOW                (WIN)
  ) dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .Clear              (Clear),
    .ResolveValid       (ResolveValid),
    .Prediction         (Prediction),
    .Outcome            (Outcome),
    .PredictionCorrect  (PredictionCorrect),
    .CorrectlyPredicted (CorrectlyPredicted),
    .TotalBranches      (TotalBranches),
    .ReportValid        (ReportValid),
    .ReportReady        (ReportReady),
    .ReportTotal        (ReportTotal),
    .ReportWindowCorrect(ReportWindowCorrect),
    .ReportOverrun      (ReportOverrun)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic branch(input logic p, input logic o);
    ResolveValid = 1'b1;
    Prediction   = p;
    Outcome      = o;
    step();
    ResolveValid = 1'b0;
  endtask

  task automatic push(input int total, input int wcorrect);
    report_t r;
    r.total    = total;
    r.wcorrect = wcorrect;
    exp_q.push_back(r);
  endtask

  task automatic check_counts(input string name, input int total, input int cp);
    check({name, "_total"}, int'(TotalBranches), total);
    check({name, "_correct"}, int'(CorrectlyPredicted), cp);
  endtask

  // Monitor: every handshake (valid & ready ahead of the edge) must match the queue head.
  initial begin
    forever begin
      @(negedge Clk);
      if (!Rst && ReportValid && ReportReady) begin
        if (exp_q.size() == 0) begin
          check_count++;
          $display("FAIL report_unexpected: got (%0d,%0d), expected no report (t=%0t)",
                   ReportTotal, ReportWindowCorrect, $time);
        end else begin
          report_t r;
          r = exp_q.pop_front();
          check("report_total", int'(ReportTotal), r.total);
          check("report_window_correct", int'(ReportWindowCorrect), r.wcorrect);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst          = 1'b1;
    Clear        = 1'b0;
    ResolveValid = 1'b0;
    Prediction   = 1'b0;
    Outcome      = 1'b0;
    ReportReady  = 1'b0;
    #12;
    check_counts("reset", 0, 0);
    check("reset_pred_correct", int'(PredictionCorrect), 0);
    check("reset_report_valid", int'(ReportValid), 0);
    check("reset_report_overrun", int'(ReportOverrun), 0);
    Rst = 1'b0;
    step();

    // Window of 4 with correctness 1,0,1,1, consumer ready.
    ReportReady = 1'b1;
    branch(1, 1);
    branch(1, 0);
    branch(0, 0);
    push(4, 3);
    branch(1, 1);
    check("a_report_valid", int'(ReportValid), 1);
    check_counts("a", 4, 3);
    check("a_pred_correct", int'(PredictionCorrect), 1);
    step();
    check("a_report_valid_one_cycle", int'(ReportValid), 0);
    check("a_pred_correct_hold", int'(PredictionCorrect), 1);

    // Eight correct branches with consumer stalled: second report dropped.
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    check_counts("b_clear", 0, 0);
    ReportReady = 1'b0;
    branch(1, 1);
    branch(1, 1);
    branch(1, 1);
    push(4, 4);
    branch(0, 0);
    check("b_report_valid", int'(ReportValid), 1);
    check("b_overrun_early", int'(ReportOverrun), 0);
    for (int i = 0; i < 4; i++) branch(1, 1);
    check("b_overrun", int'(ReportOverrun), 1);
    check("b_held_total", int'(ReportTotal), 4);
    check("b_held_correct", int'(ReportWindowCorrect), 4);
    check_counts("b", 8, 8);
    ReportReady = 1'b1;
    step();
    ReportReady = 1'b0;
    check("b_report_popped", int'(ReportValid), 0);
    check("b_overrun_sticky", int'(ReportOverrun), 1);

    // Window closes in the same cycle the held report is popped.
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    check("c_overrun_cleared", int'(ReportOverrun), 0);
    for (int i = 0; i < 3; i++) branch(1, 1);
    push(4, 4);
    branch(1, 1);
    branch(1, 1);
    branch(0, 1);
    branch(1, 1);
    push(8, 2);
    ReportReady = 1'b1;
    branch(1, 0);
    check("c_report_valid_no_gap", int'(ReportValid), 1);
    check("c_report_total", int'(ReportTotal), 8);
    check("c_report_correct", int'(ReportWindowCorrect), 2);
    check("c_overrun", int'(ReportOverrun), 0);
    step();
    check("c_report_popped", int'(ReportValid), 0);
    check_counts("c", 8, 6);

    // Clear together with a resolving branch after 3 branches.
    branch(1, 0);
    branch(0, 0);
    branch(1, 1);
    Clear        = 1'b1;
    ResolveValid = 1'b1;
    Prediction   = 1'b1;
    Outcome      = 1'b1;
    step();
    Clear        = 1'b0;
    ResolveValid = 1'b0;
    check_counts("d_clear", 0, 0);
    check("d_pred_correct", int'(PredictionCorrect), 0);
    check("d_report_valid", int'(ReportValid), 0);
    branch(0, 1);
    branch(1, 1);
    branch(0, 0);
    check("d_no_early_close", int'(ReportValid), 0);
    check_counts("d3", 3, 2);
    push(4, 2);
    branch(1, 0);
    check("d_report_valid", int'(ReportValid), 1);
    step();

    // Asynchronous reset mid-cycle with a report held, 2 branches into a window.
    ReportReady = 1'b0;
    for (int i = 0; i < 4; i++) branch(1, 1);
    check("e_held_valid", int'(ReportValid), 1);
    check("e_held_total", int'(ReportTotal), 8);
    check("e_held_correct", int'(ReportWindowCorrect), 4);
    branch(0, 0);
    branch(0, 0);
    #3;
    Rst = 1'b1;
    #1;
    check_counts("e_rst", 0, 0);
    check("e_rst_pred_correct", int'(PredictionCorrect), 0);
    check("e_rst_report_valid", int'(ReportValid), 0);
    check("e_rst_report_total", int'(ReportTotal), 0);
    check("e_rst_report_correct", int'(ReportWindowCorrect), 0);
    check("e_rst_overrun", int'(ReportOverrun), 0);
    #2;
    Rst = 1'b0;
    branch(1, 0);
    check_counts("e_first", 1, 0);
    ReportReady = 1'b1;

    // Saturation: 255 branches, then 10 more that must not close a window.
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      if (k % WIN == 0) push(k, 4);
      branch(1, 1);
    end
    check_counts("f_sat", 255, 255);
    for (int i = 0; i < 10; i++) branch(0, 1);
    check_counts("f_after", 255, 255);
    check("f_pred_correct", int'(PredictionCorrect), 0);
    step();
    step();
    check("f_no_report", int'(ReportValid), 0);
    check("f_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule : tb_branch_stats_monitor

// File: doc/branch_stats_monitor.md
BRANCH_STATS_MONITOR -- requirements
Module: branch_stats_monitor

Interface
REQ-001 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter INSTRUCTION_INDEX_SIZE, default 22, SHALL set the width of all branch counters.
REQ-003 Parameter WINDOW, default 100000, SHALL set the number of branches per hit-rate report; legal range 2 to 2**INSTRUCTION_INDEX_SIZE-1.
REQ-004 Clk  in  1  clock, rising edge.
REQ-005 Rst  in  1  asynchronous active-high reset.
REQ-006 Clear  in  1  synchronous clear of all statistics.
REQ-007 ResolveValid  in  1  one resolved branch is presented this cycle.
REQ-008 Prediction  in  1  predicted direction of the resolved branch (1 = taken).
REQ-009 Outcome  in  1  actual direction of the resolved branch.
REQ-010 PredictionCorrect  out  1  registered Prediction==Outcome for the last accepted branch.
REQ-011 CorrectlyPredicted  out  INSTRUCTION_INDEX_SIZE  running count of correct predictions.
REQ-012 TotalBranches  out  INSTRUCTION_INDEX_SIZE  running count of resolved branches.
REQ-013 ReportValid  out  1  a window report is held.
REQ-014 ReportReady  in  1  consumer accepts the held report.
REQ-015 ReportTotal  out  INSTRUCTION_INDEX_SIZE  TotalBranches at window close.
REQ-016 ReportWindowCorrect  out  INSTRUCTION_INDEX_SIZE  correct predictions within the closed window.
REQ-017 ReportOverrun  out  1  sticky: a window closed while a report was still held.

Function
REQ-018 A branch SHALL be accepted in every cycle with ResolveValid=1 and Clear=0; there is no back-pressure on the resolve side.
REQ-019 For an accepted branch, TotalBranches SHALL increment by 1, and CorrectlyPredicted SHALL increment by 1 iff Prediction==Outcome; both SHALL be visible the cycle after acceptance (latency 1).
REQ-020 PredictionCorrect SHALL update only on acceptance and hold its value otherwise.
REQ-021 Each counter SHALL saturate at all-ones and never wrap; once TotalBranches saturates, no further windows SHALL close.
REQ-022 An internal window counter SHALL count accepted branches from 0 to WINDOW-1; the acceptance that completes WINDOW branches closes the window and returns the counter to 0.
REQ-023 An internal window-correct counter SHALL count correct predictions in the current window, including those of the closing branch, and SHALL restart at 0 on close.
REQ-024 On close with the report slot empty, or with ReportValid=1 and ReportReady=1 in the same cycle, ReportTotal and ReportWindowCorrect SHALL load and ReportValid SHALL be 1 the following cycle.
REQ-025 On close with ReportValid=1 and ReportReady=0, the new report SHALL be dropped, the held report SHALL be kept unchanged, and ReportOverrun SHALL set.
REQ-026 A report SHALL be held stable until ReportValid=1 and ReportReady=1 coincide; ReportValid then clears on the next edge unless REQ-024 reloads it.
REQ-027 Clear SHALL take priority over ResolveValid: a branch presented in a Clear cycle is discarded, and all counters, PredictionCorrect, ReportValid and ReportOverrun go to 0 on that edge.
REQ-028 A correct-prediction count SHALL never exceed TotalBranches, and ReportWindowCorrect SHALL never exceed WINDOW.

Reset
REQ-029 Rst=1 SHALL immediately force all counters, PredictionCorrect, ReportValid, ReportTotal, ReportWindowCorrect and ReportOverrun to 0, including mid-window and with a report held.
REQ-030 The first branch after reset SHALL be accepted on the first rising edge at which Rst=0 and ResolveValid=1.

Structure
REQ-031 INSTRUCTION_INDEX_SIZE and WINDOW defaults SHALL live in the shared tage_pkg package and be used by TopLevel and by this block.
REQ-032 The one-entry report buffer with its valid/ready and overrun logic SHALL be a sub-module named stats_report_slot.
REQ-033 The window and saturation counters SHALL stay in the top level of branch_stats_monitor.

Verification (bench uses WINDOW=4, INSTRUCTION_INDEX_SIZE=8)
REQ-034 4 accepted branches with correctness pattern 1,0,1,1 and ReportReady=1 -> ReportValid=1 for one cycle, ReportTotal=4, ReportWindowCorrect=3, CorrectlyPredicted=3.
REQ-035 8 branches, all correct, ReportReady=0 -> first report (4,4) is held; ReportOverrun=1 after the 8th branch; the held report stays at (4,4).
REQ-036 A window closes in the same cycle that ReportReady=1 pops a held report -> the new report loads with no gap and ReportOverrun stays 0.
REQ-037 Clear and ResolveValid asserted together after 3 branches -> all counters read 0 next cycle, and the next window needs 4 further branches.
REQ-038 Rst pulsed asynchronously mid-cycle after 2 branches with a report held -> all outputs read 0 before the next edge.
REQ-039 255 branches followed by 10 more -> TotalBranches stays at 255, and no window closes after saturation.
